// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if: pipeline/cop0 side signals of the exception sequencer.
// master drives requests and status; slave is the sequencer itself.
interface exc_ctrl_if;
    logic [5:0]  irq;
    logic        sys_req, brk_req, ri_req, ovf_req, eret_req;
    logic [31:0] pc_cur, epc_in;
    logic        status_ie, status_exl, status_bev;
    logic        count_wr, compare_wr;
    logic [31:0] wr_data;
    logic        flush, stall, redirect;
    logic [31:0] redirect_pc;
    logic        epc_wr, cause_wr;
    logic [31:0] epc_data, cause_data;
    logic        exl_set, exl_clr, busy;
    logic [31:0] count_out, compare_out;

    modport master (
        output irq, sys_req, brk_req, ri_req, ovf_req, eret_req, pc_cur, epc_in,
               status_ie, status_exl, status_bev, count_wr, compare_wr, wr_data,
        input  flush, stall, redirect, redirect_pc, epc_wr, cause_wr, epc_data,
               cause_data, exl_set, exl_clr, busy, count_out, compare_out
    );
    modport slave (
        input  irq, sys_req, brk_req, ri_req, ovf_req, eret_req, pc_cur, epc_in,
               status_ie, status_exl, status_bev, count_wr, compare_wr, wr_data,
        output flush, stall, redirect, redirect_pc, epc_wr, cause_wr, epc_data,
               cause_data, exl_set, exl_clr, busy, count_out, compare_out
    );
endinterface

// File: rtl/exc_ctrl.sv
// exc_ctrl: cop0 exception/interrupt/ERET sequencer (FLUSH -> SAVE -> VECTOR, or RET).
// Define EXC_TIMER_EN to build the COUNT/COMPARE timer interrupt on IP7.
module exc_ctrl (
    input logic       clk,
    input logic       rst_n,
    exc_ctrl_if.slave bus
);
    localparam logic [31:0] EXCEPTION_ENTRY = 32'h80000180;
    localparam logic [31:0] BOOT_ENTRY      = 32'hBFC00380;

    typedef enum logic [2:0] {IDLE, FLUSH, SAVE, VECTOR, RET} state_t;

    state_t      state;
    logic        timer_pend, int_pend, exc;
    logic [4:0]  code, code_q;
    logic [7:0]  ip, ip_q;
    logic [31:0] pc_q;

`ifdef EXC_TIMER_EN
    logic [31:0] count, compare;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count      <= '0;
            compare    <= '0;
            timer_pend <= 1'b0;
        end else begin
            count <= bus.count_wr ? bus.wr_data : count + 32'd1;
            if (bus.compare_wr) begin
                compare    <= bus.wr_data;
                timer_pend <= 1'b0;
            end else if (count == compare) begin
                timer_pend <= 1'b1;
            end
        end
    end

    assign bus.count_out   = count;
    assign bus.compare_out = compare;
`else
    logic unused_timer;

    assign timer_pend      = 1'b0;
    assign bus.count_out   = '0;
    assign bus.compare_out = '0;
    assign unused_timer    = ^{bus.count_wr, bus.compare_wr, bus.wr_data};
`endif

    // IP is only recorded when the interrupt is the cause actually taken
    always_comb begin
        int_pend = (bus.irq != 6'd0 || timer_pend) && bus.status_ie && !bus.status_exl;
        exc      = int_pend || bus.ri_req || bus.sys_req || bus.brk_req || bus.ovf_req;
        code     = int_pend ? 5'd0 : bus.ri_req ? 5'd10 : bus.sys_req ? 5'd8 :
                   bus.brk_req ? 5'd9 : 5'd12;
        ip       = int_pend ? {bus.irq[5] | timer_pend, bus.irq[4:0], 2'b00} : 8'd0;
    end

    // outputs are registered alongside the next state, so each strobe lasts one state
    always_ff @(posedge clk) begin
        bus.flush       <= 1'b0;
        bus.stall       <= 1'b0;
        bus.redirect    <= 1'b0;
        bus.redirect_pc <= '0;
        bus.epc_wr      <= 1'b0;
        bus.epc_data    <= '0;
        bus.cause_wr    <= 1'b0;
        bus.cause_data  <= '0;
        bus.exl_set     <= 1'b0;
        bus.exl_clr     <= 1'b0;
        bus.busy        <= 1'b0;
        if (!rst_n) begin
            state  <= IDLE;
            code_q <= '0;
            ip_q   <= '0;
            pc_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (exc) begin
                        state     <= FLUSH;
                        code_q    <= code;
                        ip_q      <= ip;
                        pc_q      <= bus.pc_cur;
                        bus.flush <= 1'b1;
                        bus.stall <= 1'b1;
                        bus.busy  <= 1'b1;
                    end else if (bus.eret_req) begin
                        state           <= RET;
                        bus.redirect    <= 1'b1;
                        bus.redirect_pc <= bus.epc_in;
                        bus.exl_clr     <= 1'b1;
                        bus.flush       <= 1'b1;
                        bus.busy        <= 1'b1;
                    end
                end
                FLUSH: begin
                    state          <= SAVE;
                    bus.epc_wr     <= 1'b1;
                    bus.epc_data   <= pc_q;
                    bus.cause_wr   <= 1'b1;
                    bus.cause_data <= {16'b0, ip_q, 1'b0, code_q, 2'b0};
                    bus.exl_set    <= 1'b1;
                    bus.stall      <= 1'b1;
                    bus.busy       <= 1'b1;
                end
                SAVE: begin
                    state           <= VECTOR;
                    bus.redirect    <= 1'b1;
                    bus.redirect_pc <= bus.status_bev ? BOOT_ENTRY : EXCEPTION_ENTRY;
                    bus.busy        <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: table vectors, hand sequences and random requests against a timeline model.
// Timer checks run only when EXC_TIMER_EN is defined.
module tb_exc_ctrl;
    localparam logic [7:0] F = 8'h80, S = 8'h40, R = 8'h20, EW = 8'h10;
    localparam logic [7:0] CW = 8'h08, XS = 8'h04, XC = 8'h02, B = 8'h01;

    typedef struct packed {
        logic [5:0]  irq;
        logic        sys, brk, ri, ovf, eret, ie, exl, bev;
        logic [31:0] pc, epc;
    } stim_t;

    typedef struct packed {
        logic [7:0]  ctl;
        logic [31:0] rpc, epc_d, cause_d;
    } obs_t;

    typedef struct {
        string       name;
        stim_t       s;
        logic        exc;
        logic [31:0] cause, epc, rpc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    obs_t got [1:5];
    vec_t vecs [8];

    exc_ctrl_if bus ();
    exc_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    function automatic stim_t mk(input logic [5:0] irq, input logic sys, brk, ri, ovf, eret,
                                 ie, exl, bev, input logic [31:0] pc, epc);
        return '{irq:irq, sys:sys, brk:brk, ri:ri, ovf:ovf, eret:eret, ie:ie, exl:exl,
                 bev:bev, pc:pc, epc:epc};
    endfunction

    // Expected outputs k cycles after the request edge, built from the priority rules
    function automatic obs_t model(input stim_t s, input int k);
        obs_t        o;
        logic        pend;
        logic [3:0]  req;
        int          order [4];
        logic [4:0]  code;
        logic [7:0]  ip;
        o     = '0;
        pend  = s.irq != 6'd0 && s.ie && !s.exl;
        req   = {s.ri, s.sys, s.brk, s.ovf};
        order = '{10, 8, 9, 12};
        code  = 5'd0;
        for (int i = 0; i < 4; i++) if (req[i]) code = 5'(order[3 - i]);
        if (pend) code = 5'd0;
        ip = pend ? {s.irq, 2'b00} : 8'd0;
        if (pend || req != 4'd0) begin
            if (k == 1) o.ctl = F | S | B;
            if (k == 2) begin
                o.ctl     = EW | CW | XS | S | B;
                o.epc_d   = s.pc;
                o.cause_d = (32'(ip) << 8) | (32'(code) << 2);
            end
            if (k == 3) begin
                o.ctl = R | B;
                o.rpc = s.bev ? 32'hBFC00380 : 32'h80000180;
            end
        end else if (s.eret && k == 1) begin
            o.ctl = R | XC | F | B;
            o.rpc = s.epc;
        end
        return o;
    endfunction

    function automatic obs_t sample();
        return '{ctl:{bus.flush, bus.stall, bus.redirect, bus.epc_wr, bus.cause_wr,
                      bus.exl_set, bus.exl_clr, bus.busy},
                 rpc:bus.redirect_pc, epc_d:bus.epc_data, cause_d:bus.cause_data};
    endfunction

    task automatic chk_obs(input string name, input obs_t a, input obs_t e);
        chk({name, " ctl"}, 32'(a.ctl), 32'(e.ctl));
        chk({name, " rpc"}, a.rpc, e.rpc);
        chk({name, " epc"}, a.epc_d, e.epc_d);
        chk({name, " cause"}, a.cause_d, e.cause_d);
    endtask

    task automatic drive(input stim_t s);
        bus.irq        = s.irq;
        bus.sys_req    = s.sys;
        bus.brk_req    = s.brk;
        bus.ri_req     = s.ri;
        bus.ovf_req    = s.ovf;
        bus.eret_req   = s.eret;
        bus.status_ie  = s.ie;
        bus.status_exl = s.exl;
        bus.status_bev = s.bev;
        bus.pc_cur     = s.pc;
        bus.epc_in     = s.epc;
    endtask

    task automatic clear_req();
        bus.irq      = '0;
        bus.sys_req  = 1'b0;
        bus.brk_req  = 1'b0;
        bus.ri_req   = 1'b0;
        bus.ovf_req  = 1'b0;
        bus.eret_req = 1'b0;
    endtask

    // one-cycle request, then four sampled cycles compared with the model
    task automatic run(input string name, input stim_t s);
        @(negedge clk);
        drive(s);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            got[k] = sample();
            if (k == 1) clear_req();
            chk_obs($sformatf("%s c%0d", name, k), got[k], model(s, k));
        end
    endtask

    // a fresh reset leaves COUNT == COMPARE, so park COMPARE far away as reset lifts
    task automatic release_rst();
        rst_n = 1'b1;
`ifdef EXC_TIMER_EN
        bus.compare_wr = 1'b1;
        bus.wr_data    = 32'h7FFFFFFF;
`endif
        @(negedge clk);
        bus.compare_wr = 1'b0;
    endtask

    initial begin
        stim_t s;
        vecs[0] = '{name:"sys", s:mk(6'h00,1,0,0,0,0,0,0,0,32'h00400020,0), exc:1,
                    cause:32'h00000020, epc:32'h00400020, rpc:32'h80000180};
        vecs[1] = '{name:"irq_vs_ovf", s:mk(6'h01,0,0,0,1,0,1,0,0,32'h00401000,0), exc:1,
                    cause:32'h00000400, epc:32'h00401000, rpc:32'h80000180};
        vecs[2] = '{name:"ovf_exl", s:mk(6'h01,0,0,0,1,0,1,1,0,32'h00401004,0), exc:1,
                    cause:32'h00000030, epc:32'h00401004, rpc:32'h80000180};
        vecs[3] = '{name:"eret", s:mk(6'h00,0,0,0,0,1,0,1,0,32'h0,32'h00400040), exc:0,
                    cause:32'h0, epc:32'h0, rpc:32'h00400040};
        vecs[4] = '{name:"eret_brk", s:mk(6'h00,0,1,0,0,1,0,0,0,32'h00400050,32'h00400040),
                    exc:1, cause:32'h00000024, epc:32'h00400050, rpc:32'h80000180};
        vecs[5] = '{name:"brk_bev", s:mk(6'h00,0,1,0,0,0,0,0,1,32'h00400060,0), exc:1,
                    cause:32'h00000024, epc:32'h00400060, rpc:32'hBFC00380};
        vecs[6] = '{name:"ri_sys", s:mk(6'h00,1,0,1,0,0,0,0,0,32'h00400070,0), exc:1,
                    cause:32'h00000028, epc:32'h00400070, rpc:32'h80000180};
        vecs[7] = '{name:"ip7_sys", s:mk(6'h20,1,0,0,0,0,1,0,0,32'h00400080,0), exc:1,
                    cause:32'h00008000, epc:32'h00400080, rpc:32'h80000180};

        drive('0);
        bus.count_wr   = 1'b0;
        bus.compare_wr = 1'b0;
        bus.wr_data    = '0;
        repeat (3) @(negedge clk);
        chk_obs("reset", sample(), '0);
        release_rst();
        chk_obs("after reset", sample(), '0);

        foreach (vecs[i]) begin
            run(vecs[i].name, vecs[i].s);
            if (vecs[i].exc) begin
                chk({vecs[i].name, " cause_data"}, got[2].cause_d, vecs[i].cause);
                chk({vecs[i].name, " epc_data"}, got[2].epc_d, vecs[i].epc);
                chk({vecs[i].name, " vector"}, got[3].rpc, vecs[i].rpc);
                chk({vecs[i].name, " no exl_clr"}, 32'(got[1].ctl[1]), 32'd0);
            end else begin
                chk({vecs[i].name, " target"}, got[1].rpc, vecs[i].rpc);
                chk({vecs[i].name, " exl_clr"}, 32'(got[1].ctl[1]), 32'd1);
                chk({vecs[i].name, " idle after 2"}, 32'(got[2].ctl[0]), 32'd0);
            end
        end

        // reset while in SAVE aborts the sequence
        @(negedge clk);
        drive(mk(6'h00,1,0,0,0,0,0,0,0,32'h00400100,0));
        @(negedge clk);
        clear_req();
        @(negedge clk);
        chk("rst_save in SAVE", 32'(bus.epc_wr), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_obs("rst_save cleared", sample(), '0);
        release_rst();
        chk_obs("rst_save no redirect", sample(), '0);
        run("post_rst sys", mk(6'h00,1,0,0,0,0,0,0,0,32'h00400104,0));

        // held request: ignored while busy, retaken on the first idle cycle
        s = mk(6'h00,1,0,0,0,0,0,0,0,32'h00400200,0);
        @(negedge clk);
        drive(s);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk_obs($sformatf("b2b c%0d", k), sample(), model(s, k == 5 ? 1 : k));
        end
        clear_req();
        repeat (4) @(negedge clk);
        chk("b2b drained", 32'(bus.busy), 32'd0);

`ifdef EXC_TIMER_EN
        @(negedge clk);
        bus.status_ie  = 1'b1;
        bus.status_exl = 1'b0;
        bus.status_bev = 1'b0;
        bus.count_wr   = 1'b1;
        bus.wr_data    = 32'hFFFFFFFE;
        @(negedge clk);
        bus.count_wr   = 1'b0;
        bus.compare_wr = 1'b1;
        bus.wr_data    = 32'h00000001;
        @(negedge clk);
        bus.compare_wr = 1'b0;
        chk("count ff", bus.count_out, 32'hFFFFFFFF);
        chk("compare", bus.compare_out, 32'h00000001);
        @(negedge clk);
        chk("count wrap", bus.count_out, 32'h0);
        @(negedge clk);
        chk("count 1", bus.count_out, 32'h1);
        @(negedge clk);
        chk("timer not yet taken", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("timer flush", 32'(sample().ctl), 32'(F | S | B));
        @(negedge clk);
        chk("timer cause", bus.cause_data, 32'h00008000);
        bus.status_ie = 1'b0;
        repeat (2) @(negedge clk);
        bus.compare_wr = 1'b1;
        bus.wr_data    = 32'h7FFFFFFF;
        @(negedge clk);
        bus.compare_wr = 1'b0;
        bus.status_ie  = 1'b1;
        repeat (3) @(negedge clk);
        chk("timer pend cleared", 32'(bus.busy), 32'd0);
        bus.status_ie = 1'b0;
`else
        @(negedge clk);
        bus.count_wr   = 1'b1;
        bus.compare_wr = 1'b1;
        bus.wr_data    = 32'h12345678;
        @(negedge clk);
        bus.count_wr   = 1'b0;
        bus.compare_wr = 1'b0;
        chk("count off", bus.count_out, 32'h0);
        chk("compare off", bus.compare_out, 32'h0);
        @(negedge clk);
        chk("no timer irq", 32'(bus.busy), 32'd0);
`endif

        for (int i = 0; i < 60; i++) begin
            s.irq  = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            s.sys  = $urandom_range(0, 4) == 0;
            s.brk  = $urandom_range(0, 4) == 0;
            s.ri   = $urandom_range(0, 4) == 0;
            s.ovf  = $urandom_range(0, 4) == 0;
            s.eret = $urandom_range(0, 2) == 0;
            s.ie   = 1'($urandom);
            s.exl  = 1'($urandom);
            s.bev  = 1'($urandom);
            s.pc   = $urandom;
            s.epc  = $urandom;
            run($sformatf("rand%0d", i), s);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception and interrupt sequencer for coprocessor 0. Collects synchronous exception requests (syscall, break, reserved instruction, overflow), external interrupt lines and an optional internal timer interrupt. Prioritises them against the current status bits and runs a fixed multi-cycle sequence: flush the pipeline, write EPC/CAUSE, set EXL, redirect the PC. Also sequences ERET. Sits between the pipeline control unit and the cop0 register file.

## Interface
- EXCEPTION_ENTRY, 32'h80000180, vector when BEV=0
- BOOT_ENTRY, 32'hBFC00380, vector when BEV=1
- clk  in  1  clock, all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- irq  in  6  external interrupt lines, level, map to CAUSE.IP[7:2] (bits 15:10)
- sys_req, brk_req, ri_req, ovf_req  in  1 each  exception requests from the pipeline, valid only while idle
- eret_req  in  1  ERET issued
- pc_cur  in  32  PC of the faulting or current instruction
- epc_in  in  32  current EPC from cop0, used by ERET
- status_ie, status_exl, status_bev  in  1 each  STATUS bits 0, 1 and 22
- count_wr, compare_wr  in  1 each  mtc0 write strobes for COUNT and COMPARE
- wr_data  in  32  mtc0 data
- flush  out  1  kill instructions in flight
- stall  out  1  hold the PC and the IF/ID stages
- redirect  out  1  load redirect_pc into the PC
- redirect_pc  out  32  target PC
- epc_wr, cause_wr  out  1 each  cop0 write strobes
- epc_data, cause_data  out  32 each  cop0 write data
- exl_set, exl_clr  out  1 each  STATUS.EXL control pulses
- busy  out  1  FSM not in IDLE
- count_out, compare_out  out  32 each  timer registers (0 when timer compiled out)

## Operation
- FSM states: IDLE, FLUSH, SAVE, VECTOR, RET.
- Pending interrupt: (irq != 0 || timer_pend) && status_ie && !status_exl.
- Priority, highest first: interrupt (ExcCode 0), ri (10), sys (8), brk (9), ovf (12).
- IDLE leaves on any request. Target state is FLUSH for an exception or interrupt, and RET for eret_req alone.
- If eret_req arrives together with an exception or interrupt, the exception wins and eret is dropped.
- The winning cause, pc_cur and the IP vector are latched on the IDLE exit edge.
- FLUSH: flush=1, stall=1.
- SAVE: epc_wr=1 with epc_data=latched PC. cause_wr=1 with cause_data = {16'b0, IP[7:0], 1'b0, ExcCode[4:0], 2'b0}. exl_set=1, stall=1.
- VECTOR: redirect=1, redirect_pc = status_bev ? BOOT_ENTRY : EXCEPTION_ENTRY. Then return to IDLE.
- RET: redirect=1, redirect_pc=epc_in, exl_clr=1, flush=1. Then return to IDLE.
- Requests arriving while busy=1 are ignored. The pipeline is stalled or flushed at that time and re-raises them as needed.
- Exceptions are taken even when status_exl=1. EPC is overwritten in that case.
- Reset: FSM goes to IDLE. All outputs go to 0. Latches, count and compare clear. timer_pend clears. A reset mid-sequence aborts with no partial cop0 write after the reset edge.

## Timing
- Request sampled at edge N. FLUSH is active in cycle N+1, SAVE in N+2, VECTOR in N+3. IDLE is re-entered at N+4.
- ERET: request at N, RET in N+1, IDLE at N+2.
- Every strobe output (flush, redirect, epc_wr, cause_wr, exl_set, exl_clr) is a single-cycle pulse registered from FSM state.
- busy is high in every non-IDLE state.
- Back-to-back: a new request held high is accepted on the first cycle back in IDLE.

## Configuration
- EXC_TIMER_EN defined: 32-bit COUNT increments every cycle and wraps 32'hFFFFFFFF -> 0.
  - count_wr loads wr_data, which takes priority over the increment.
  - compare_wr loads COMPARE and clears timer_pend.
  - timer_pend sets on the cycle COUNT equals COMPARE, unless compare_wr is asserted in that cycle.
  - timer_pend drives IP7, ORed with irq[5].
- EXC_TIMER_EN undefined: no timer logic. timer_pend=0. count_out and compare_out read 0. count_wr and compare_wr are ignored.

## Test plan
- sys_req with pc_cur=32'h00400020, BEV=0 -> FLUSH, SAVE and VECTOR on consecutive cycles. epc_data=32'h00400020, cause_data=32'h00000020, redirect_pc=32'h80000180.
- irq=6'b000001, IE=1, EXL=0, ovf_req=1 in the same cycle -> interrupt wins. cause_data=32'h00000400. With EXL=1 the same stimulus takes ovf instead, cause_data=32'h00000030.
- eret_req with epc_in=32'h00400040 -> next cycle redirect=1, redirect_pc=32'h00400040, exl_clr=1, busy=0 after 2 cycles. eret together with brk_req -> brk sequence taken, no exl_clr.
- BEV=1, brk_req -> redirect_pc=32'hBFC00380, cause_data=32'h00000024.
- EXC_TIMER_EN: count_wr 32'hFFFFFFFE, compare_wr 32'h00000001, IE=1 -> COUNT wraps through 0. Interrupt taken with cause_data bit 15 set, and a later compare_wr clears pending.
- rst_n low during SAVE -> next cycle all outputs 0, no redirect. A fresh sys_req afterwards completes normally.
